// File: rtl/mul_sequencer.sv
//------------------------------------------------------------------------------
// +----------------------------------------------------------------------------+
// | Module      : mul_sequencer                                                |
// | Description : Iterative shift-and-add multiplier sequencer for the EX      |
// |               stage. It stalls the front of the pipeline while a multiply  |
// |               runs and presents the low WIDTH bits of the product for one  |
// |               cycle with done_o.                                           |
// | Options     : `define MUL_EARLY_TERM_EN to finish as soon as the remaining |
// |               multiplier bits are all zero.                                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
//------------------------------------------------------------------------------
`default_nettype none

module mul_sequencer #(
   parameter int          WIDTH    = 32,
   parameter logic [3:0]  MUL_CODE = 4'b1001
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             valid_i,
   input  logic [3:0]       ALUCtrl_i,
   input  logic [WIDTH-1:0] data1_i,
   input  logic [WIDTH-1:0] data2_i,
   input  logic             flush_i,
   output logic             stall_o,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] result_o
);

   // Step counter only has to reach WIDTH-1.
   localparam int                CNT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0]  C_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;

   logic [WIDTH-1:0]    r_acc;
   logic [WIDTH-1:0]    r_mcand;
   logic [WIDTH-1:0]    r_mplier;
   logic [CNT_W-1:0]    r_count;
   logic [WIDTH-1:0]    r_result;

   logic                w_req;
   logic [WIDTH-1:0]    w_acc_step;
   logic [WIDTH-1:0]    w_mcand_shift;
   logic [WIDTH-1:0]    w_mplier_shift;
   logic                w_last;
   logic                w_stall;

   assign w_req = valid_i && (ALUCtrl_i == MUL_CODE);

   // One shift-and-add step; sums wrap modulo 2^WIDTH so the low word is
   // correct for both signed and unsigned operands.
   always_comb begin
      w_acc_step     = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
      w_mcand_shift  = r_mcand << 1;
      w_mplier_shift = r_mplier >> 1;
`ifdef MUL_EARLY_TERM_EN
      // Stop once no set multiplier bits remain; the count bound still applies.
      w_last         = (r_count == C_LAST) || (w_mplier_shift == '0);
`else
      w_last         = (r_count == C_LAST);
`endif
   end

   // State register; reset wins over everything else.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and stall decode; flush overrides any request or step.
   always_comb begin
      w_state_nxt = r_state;
      w_stall     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (flush_i) begin
               w_state_nxt = ST_IDLE;
            end else if (w_req) begin
               w_state_nxt = ST_RUN;
               w_stall     = 1'b1;
            end
         end
         ST_RUN: begin
            if (flush_i) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_stall = 1'b1;
               if (w_last) begin
                  w_state_nxt = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            // Result is consumed this cycle; the same request is not re-taken.
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Operand latch, iteration datapath and result capture.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_acc    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_count  <= '0;
         r_result <= '0;
      end else if (flush_i) begin
         r_count  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_req) begin
                  r_mcand  <= data1_i;
                  r_mplier <= data2_i;
                  r_acc    <= '0;
                  r_count  <= '0;
               end
            end
            ST_RUN: begin
               r_acc    <= w_acc_step;
               r_mcand  <= w_mcand_shift;
               r_mplier <= w_mplier_shift;
               r_count  <= r_count + CNT_W'(1);
               if (w_last) begin
                  r_result <= w_acc_step;
               end
            end
            default: begin
               r_count <= r_count;
            end
         endcase
      end
   end

   assign stall_o  = w_stall;
   assign busy_o   = (r_state == ST_RUN);
   assign done_o   = (r_state == ST_DONE);
   assign result_o = r_result;

endmodule

`default_nettype wire

// File: tb/tb_mul_sequencer.sv
//------------------------------------------------------------------------------
// +----------------------------------------------------------------------------+
// | Module      : tb_mul_sequencer                                             |
// | Description : Directed self-checking bench for mul_sequencer.              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
//------------------------------------------------------------------------------
`default_nettype none

module tb_mul_sequencer;

   localparam int         WIDTH    = 32;
   localparam logic [3:0] MUL_CODE = 4'b1001;

   logic             clk = 1'b0;
   logic             rst_i;
   logic             valid_i;
   logic [3:0]       ALUCtrl_i;
   logic [WIDTH-1:0] data1_i;
   logic [WIDTH-1:0] data2_i;
   logic             flush_i;
   logic             stall_o;
   logic             busy_o;
   logic             done_o;
   logic [WIDTH-1:0] result_o;

   int n_checks = 0;
   int n_errors = 0;

   mul_sequencer #(.WIDTH(WIDTH), .MUL_CODE(MUL_CODE)) dut (
      .clk_i     (clk),
      .rst_i     (rst_i),
      .valid_i   (valid_i),
      .ALUCtrl_i (ALUCtrl_i),
      .data1_i   (data1_i),
      .data2_i   (data2_i),
      .flush_i   (flush_i),
      .stall_o   (stall_o),
      .busy_o    (busy_o),
      .done_o    (done_o),
      .result_o  (result_o)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Number of RUN cycles the current build should take for a multiplier.
   function automatic int exp_run_cycles(input logic [WIDTH-1:0] b);
      int n;
`ifdef MUL_EARLY_TERM_EN
      n = 1;
      for (int k = 0; k < WIDTH; k++) begin
         if (b[k]) n = k + 1;
      end
`else
      n = WIDTH;
`endif
      return n;
   endfunction

   // Issue one multiply, hold the instruction until DONE, verify timing/result.
   task automatic run_mul(input string tag, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] exp);
      int runs;
      valid_i   = 1'b1;
      ALUCtrl_i = MUL_CODE;
      data1_i   = a;
      data2_i   = b;
      #1;
      check({tag, "_stall_req"}, {31'd0, stall_o}, 32'd1);
      tick();
      runs = 0;
      for (int i = 0; i < 100 && busy_o; i++) begin
         if (!stall_o) check({tag, "_stall_run"}, {31'd0, stall_o}, 32'd1);
         runs++;
         tick();
      end
      check({tag, "_run_cycles"}, runs, exp_run_cycles(b));
      check({tag, "_done"},       {31'd0, done_o}, 32'd1);
      check({tag, "_result"},     result_o, exp);
      check({tag, "_stall_done"}, {31'd0, stall_o}, 32'd0);
      // Request still presented during DONE must not restart.
      tick();
      valid_i = 1'b0;
      #1;
      check({tag, "_no_reaccept"}, {30'd0, busy_o, done_o}, 32'd0);
      check({tag, "_hold"},        result_o, exp);
   endtask

   initial begin
      int   seen;
      rst_i     = 1'b1;
      valid_i   = 1'b0;
      ALUCtrl_i = 4'b0000;
      data1_i   = '0;
      data2_i   = '0;
      flush_i   = 1'b0;
      tick();
      tick();
      check("reset_outs", {29'd0, stall_o, busy_o, done_o}, 32'd0);
      check("reset_result", result_o, 32'd0);
      rst_i = 1'b0;
      tick();

      // Basic multiply: 33 stall cycles in the default build.
      run_mul("mul7x6", 32'd7, 32'd6, 32'd42);
      run_mul("mulmax", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
      run_mul("mulneg", 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1);
      run_mul("mul3x5", 32'd3, 32'd5, 32'd15);
      run_mul("mulzero", 32'd1234, 32'd0, 32'd0);

      // Non-multiply code never stalls.
      valid_i   = 1'b1;
      ALUCtrl_i = 4'b0010;
      data1_i   = 32'd9;
      data2_i   = 32'd9;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         #1;
         if (stall_o || busy_o || done_o) seen++;
         tick();
      end
      check("nonmul_quiet", seen, 32'd0);
      valid_i = 1'b0;

      // Flush on the 10th RUN cycle aborts without a done pulse.
      valid_i   = 1'b1;
      ALUCtrl_i = MUL_CODE;
      data1_i   = 32'd100;
      data2_i   = 32'hF000_0003;
      tick();
      for (int i = 0; i < 9; i++) tick();
      check("flush_busy_before", {31'd0, busy_o}, 32'd1);
      flush_i = 1'b1;
      #1;
      check("flush_stall_low", {31'd0, stall_o}, 32'd0);
      tick();
      flush_i = 1'b0;
      valid_i = 1'b0;
      #1;
      check("flush_idle", {29'd0, stall_o, busy_o, done_o}, 32'd0);
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (done_o || busy_o) seen++;
         tick();
      end
      check("flush_no_done", seen, 32'd0);
      check("flush_result_held", result_o, 32'd0);

      // Flush beats a request in IDLE.
      valid_i   = 1'b1;
      ALUCtrl_i = MUL_CODE;
      data1_i   = 32'd2;
      data2_i   = 32'd2;
      flush_i   = 1'b1;
      #1;
      check("flush_req_stall", {31'd0, stall_o}, 32'd0);
      tick();
      check("flush_req_idle", {31'd0, busy_o}, 32'd0);
      flush_i = 1'b0;
      valid_i = 1'b0;
      tick();

      // Give result_o a nonzero value, then reset in the middle of RUN.
      run_mul("premul", 32'd11, 32'd11, 32'd121);
      valid_i   = 1'b1;
      ALUCtrl_i = MUL_CODE;
      data1_i   = 32'd5;
      data2_i   = 32'hFFFF_FFFF;
      tick();
      for (int i = 0; i < 4; i++) tick();
      check("rst_mid_busy", {31'd0, busy_o}, 32'd1);
      rst_i   = 1'b1;
      flush_i = 1'b1;
      tick();
      valid_i = 1'b0;
      flush_i = 1'b0;
      #1;
      check("rst_mid_outs", {29'd0, stall_o, busy_o, done_o}, 32'd0);
      check("rst_mid_result", result_o, 32'd0);
      rst_i = 1'b0;
      tick();
      run_mul("postrst", 32'd12, 32'd13, 32'd156);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Absolute time bound so the run always terminates.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire

// File: doc/mul_sequencer.md
MUL_SEQUENCER -- requirements
Module: mul_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width in bits.
REQ-002 The block SHALL have parameter MUL_CODE, default 4'b1001, giving the ALU control code that selects multiply.
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port valid_i, input, 1 bit: the EX-stage instruction is valid.
REQ-006 The block SHALL have port ALUCtrl_i, input, 4 bits: the ALU control code of the EX-stage instruction.
REQ-007 The block SHALL have ports data1_i and data2_i, input, WIDTH bits each: multiplicand and multiplier.
REQ-008 The block SHALL have port flush_i, input, 1 bit: abort any multiply in progress.
REQ-009 The block SHALL have port stall_o, output, 1 bit: hold the PC and the IF/ID and ID/EX registers.
REQ-010 The block SHALL have port busy_o, output, 1 bit: a multiply is executing (state RUN).
REQ-011 The block SHALL have port done_o, output, 1 bit: result_o is valid this cycle.
REQ-012 The block SHALL have port result_o, output, WIDTH bits: the low WIDTH bits of data1_i*data2_i.

Function
REQ-013 The state machine SHALL have exactly three states: IDLE, RUN and DONE.
REQ-014 A request SHALL be defined as req = valid_i && (ALUCtrl_i == MUL_CODE).
REQ-015 In IDLE with req high, the block SHALL latch the operands, clear the accumulator and the counter, and move to RUN.
REQ-016 In IDLE with req low, the block SHALL stay in IDLE; non-multiply codes SHALL never cause a stall.
REQ-017 Each RUN cycle SHALL perform one step: if mplier[0]=1 then acc += mcand; then mcand <<= 1; mplier >>= 1; count += 1.
REQ-018 All RUN arithmetic SHALL be modulo 2^WIDTH, unsigned, with carries beyond WIDTH discarded (low word matches signed and unsigned multiply).
REQ-019 The block SHALL leave RUN for DONE on the step where count == WIDTH-1, giving WIDTH RUN cycles by default.
REQ-020 In DONE, done_o SHALL be 1 and result_o SHALL equal acc for exactly one cycle, after which the state SHALL return to IDLE unconditionally.
REQ-021 In DONE, the request that produced the result SHALL NOT be re-accepted.
REQ-022 stall_o SHALL be (state==IDLE && req) || state==RUN, combinationally, so the requesting instruction is held from its first EX cycle.
REQ-023 stall_o SHALL be 0 in DONE, so the pipeline advances with result_o.
REQ-024 Default latency SHALL be: request seen at cycle T, RUN during T+1..T+WIDTH, DONE at T+WIDTH+1, stall_o high during T..T+WIDTH.
REQ-025 result_o SHALL hold its last DONE value outside DONE, and consumers SHALL qualify it with done_o.
REQ-026 flush_i in any state SHALL force IDLE on the next edge and clear count; done_o SHALL NOT pulse for the aborted operation.
REQ-027 flush_i SHALL have priority over req, so a flush in IDLE with req high leaves the state in IDLE.
REQ-028 While flush_i is high, stall_o SHALL be 0.

Reset
REQ-029 With rst_i high at a clock edge, the block SHALL enter IDLE and clear count, acc, mcand, mplier and result_o to 0.
REQ-030 During and after reset, stall_o, busy_o and done_o SHALL be 0.
REQ-031 Reset SHALL take priority over flush_i and req, including in the middle of a RUN.

Configuration
REQ-032 Macro MUL_EARLY_TERM_EN SHALL enable early termination when it is defined.
REQ-033 When MUL_EARLY_TERM_EN is defined, RUN SHALL also go to DONE on any step whose shifted mplier is 0.
REQ-034 With early termination, the number of RUN cycles SHALL be (index of the highest set bit of data2_i)+1, with a minimum of 1 when data2_i=0.
REQ-035 When MUL_EARLY_TERM_EN is undefined, the block SHALL always take exactly WIDTH RUN cycles; result values SHALL be identical in both builds.

Verification
REQ-036 Scenario: reset, then valid_i=1, ALUCtrl_i=4'b1001, data1_i=7, data2_i=6 -> stall_o high for 33 cycles, then done_o=1 with result_o=42 (default build).
REQ-037 Scenario: data1_i=32'hFFFFFFFF, data2_i=32'hFFFFFFFF -> result_o=32'h00000001.
REQ-038 Scenario: ALUCtrl_i=4'b0010 with valid_i=1 -> stall_o, busy_o and done_o stay 0 for all cycles.
REQ-039 Scenario: a multiply is started and flush_i=1 on the 10th RUN cycle -> next cycle IDLE with stall_o=0, and no done_o pulse.
REQ-040 Scenario: MUL_EARLY_TERM_EN defined, data1_i=3, data2_i=5 -> 3 RUN cycles, then done_o=1 with result_o=15; with data2_i=0 -> 1 RUN cycle and result_o=0.
REQ-041 Scenario: rst_i=1 mid-RUN -> next cycle all outputs are 0 and state is IDLE; a new request is then accepted normally.
